// File: rtl/pc_predict_unit_if.sv
// Fetch/execute bus between the core pipeline and the next-PC predictor.
// The core is the master; pc_predict_unit is the slave.
interface pc_predict_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jalr;
  logic [2:0]      ex_f3;
  logic            ex_zero;
  logic            ex_lt;
  logic            ex_ltu;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            flush;

  modport master (
    output stall, ex_valid, ex_branch, ex_jump, ex_jalr, ex_f3,
           ex_zero, ex_lt, ex_ltu, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    input  pc, pred_taken, pred_target, flush
  );

  modport slave (
    input  stall, ex_valid, ex_branch, ex_jump, ex_jalr, ex_f3,
           ex_zero, ex_lt, ex_ltu, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    output pc, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register with direct-mapped BTB and 2-bit BHT prediction;
// resolves RV32I branches/jumps in execute and redirects fetch on a mispredict.
module pc_predict_unit #(
  parameter int              XLEN     = 32,
  parameter int              ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  pc_predict_unit_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  logic [XLEN-1:0] pc_r;
  logic            btb_valid_r  [ENTRIES];
  logic            btb_isjump_r [ENTRIES];
  logic [TW-1:0]   btb_tag_r    [ENTRIES];
  logic [XLEN-1:0] btb_target_r [ENTRIES];
  logic [1:0]      bht_r        [ENTRIES];

  logic [IW-1:0]   fetch_idx_s;
  logic [TW-1:0]   fetch_tag_s;
  logic            hit_s;
  logic            pred_taken_s;
  logic [XLEN-1:0] pred_target_s;
  logic            taken_s;
  logic [XLEN-1:0] actual_next_s;
  logic            mispredict_s;
  logic            is_branch_s;
  logic            is_jump_s;
  logic            upd_s;
  logic [IW-1:0]   upd_idx_s;
  logic [TW-1:0]   upd_tag_s;

  // Fetch-side prediction from the current PC and pre-edge table contents
  always_comb begin
    fetch_idx_s   = pc_r[IW+1:2];
    fetch_tag_s   = pc_r[XLEN-1:IW+2];
    hit_s         = btb_valid_r[fetch_idx_s] && (btb_tag_r[fetch_idx_s] == fetch_tag_s);
    pred_taken_s  = hit_s && (btb_isjump_r[fetch_idx_s] || bht_r[fetch_idx_s][1]);
    if (pred_taken_s) begin
      pred_target_s = btb_target_r[fetch_idx_s];
    end else begin
      pred_target_s = pc_r + PC_STEP;
    end
  end

  // Execute-stage resolution; class priority is jump > branch > jalr
  always_comb begin
    taken_s = 1'b0;
    if (bus.ex_valid) begin
      if (bus.ex_jump) begin
        taken_s = 1'b1;
      end else if (bus.ex_branch) begin
        case (bus.ex_f3)
          3'b000:  taken_s = bus.ex_zero;
          3'b001:  taken_s = !bus.ex_zero;
          3'b100:  taken_s = bus.ex_lt;
          3'b101:  taken_s = !bus.ex_lt;
          3'b110:  taken_s = bus.ex_ltu;
          3'b111:  taken_s = !bus.ex_ltu;
          default: taken_s = 1'b0;
        endcase
      end else if (bus.ex_jalr) begin
        taken_s = 1'b1;
      end else begin
        taken_s = 1'b0;
      end
    end else begin
      taken_s = 1'b0;
    end
  end

  // Actual next PC, mispredict detection and table-update qualifiers
  always_comb begin
    if (taken_s) begin
      actual_next_s = bus.ex_target;
    end else begin
      actual_next_s = bus.ex_pc + PC_STEP;
    end
    mispredict_s = bus.ex_valid &&
                   ((taken_s != bus.ex_pred_taken) ||
                    (taken_s && (bus.ex_target != bus.ex_pred_target)));
    is_branch_s  = bus.ex_branch && !bus.ex_jump;
    is_jump_s    = bus.ex_jump || (bus.ex_jalr && !bus.ex_branch);
    upd_s        = bus.ex_valid && (bus.ex_branch || bus.ex_jump || bus.ex_jalr);
    upd_idx_s    = bus.ex_pc[IW+1:2];
    upd_tag_s    = bus.ex_pc[XLEN-1:IW+2];
  end

  // Fetch PC register: redirect beats stall beats prediction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (mispredict_s) begin
      pc_r <= actual_next_s;
    end else if (bus.stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pred_target_s;
    end
  end

  // BTB/BHT training from resolved control-flow instructions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_isjump_r[i] <= 1'b0;
        btb_tag_r[i]    <= {TW{1'b0}};
        btb_target_r[i] <= {XLEN{1'b0}};
        bht_r[i]        <= 2'b01;
      end
    end else if (upd_s) begin
      if (is_branch_s) begin
        if (taken_s) begin
          if (bht_r[upd_idx_s] != 2'b11) begin
            bht_r[upd_idx_s] <= bht_r[upd_idx_s] + 2'd1;
          end
        end else if (bht_r[upd_idx_s] != 2'b00) begin
          bht_r[upd_idx_s] <= bht_r[upd_idx_s] - 2'd1;
        end
      end
      if (taken_s) begin
        btb_valid_r[upd_idx_s]  <= 1'b1;
        btb_isjump_r[upd_idx_s] <= is_jump_s;
        btb_tag_r[upd_idx_s]    <= upd_tag_s;
        btb_target_r[upd_idx_s] <= bus.ex_target;
      end
    end
  end

  assign bus.pc          = pc_r;
  assign bus.pred_taken  = pred_taken_s;
  assign bus.pred_target = pred_target_s;
  assign bus.flush       = mispredict_s;
endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised next-PC generator for the pipelined RISC-V core, replacing the single-cycle PC-source mux. It owns the fetch PC register and predicts branch/jump direction and target in fetch, using a direct-mapped branch target buffer (BTB) and a 2-bit saturating branch history table (BHT). It resolves all six RV32I branch conditions plus JAL/JALR in the execute stage. On a misprediction it redirects fetch and raises a flush.

## Interface
- XLEN, 32, PC and target width
- ENTRIES, 16, BTB/BHT entry count; power of two, at least 2; index = pc[log2(ENTRIES)+1:2]
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold fetch PC; ignored when a redirect is active
- pc  out  XLEN  current fetch PC (registered)
- pred_taken  out  1  fetch prediction for pc; carried down the pipe by the core
- pred_target  out  XLEN  predicted next PC for pc; carried down the pipe
- ex_valid  in  1  execute stage holds a real instruction
- ex_branch, ex_jump, ex_jalr  in  1 each  instruction class in execute
- ex_f3  in  3  funct3 of the execute instruction
- ex_zero, ex_lt, ex_ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- ex_pc  in  XLEN  PC of the execute instruction
- ex_target  in  XLEN  computed target: pc+imm for branch/JAL, rs1+imm with bit 0 cleared for JALR
- ex_pred_taken, ex_pred_target  in  1 / XLEN  prediction that was made when this instruction was fetched
- flush  out  1  kill younger instructions in fetch and decode (combinational)

## Operation
- **Taken resolution** (only when ex_valid):
  - Class priority is jump > branch > jalr.
  - jump and jalr are always taken.
  - branch with f3 = 000 beq: zero; 001 bne: !zero; 100 blt: lt; 101 bge: !lt; 110 bltu: ltu; 111 bgeu: !ltu.
  - branch with f3 = 010 or 011 is never taken.
  - No class asserted: not taken.
- **Actual next PC**: ex_target if taken, else ex_pc+4 (mod 2^XLEN).
- **Mispredict** (drives flush) = ex_valid & (taken != ex_pred_taken | (taken & ex_target != ex_pred_target)).
- **Fetch prediction** (combinational from pc and current table state):
  - A hit requires btb_valid[idx] and btb_tag[idx] == pc[XLEN-1:log2(ENTRIES)+2].
  - pred_taken = hit & (btb_isjump[idx] | bht[idx] >= 2).
  - pred_target = pred_taken ? btb_target[idx] : pc+4.
- **PC update** at each edge, in priority order:
  1. flush: pc <= actual next PC.
  2. stall: hold.
  3. otherwise: pc <= pred_target.
- **Table update** (at the edge, only when ex_valid and the instruction is branch, jump or jalr); the index is taken from ex_pc.
  - BHT, branches only: increment if taken, decrement if not, saturating at 0 and 3.
  - BTB, when taken: write valid=1, tag, target=ex_target, isjump=(jump|jalr).
  - BTB, not-taken branch: BTB entry left unchanged.
  - An update to a different index evicts the occupant.
- **Same-index fetch and update in one cycle**: the fetch read sees pre-edge contents; there is no bypass.
- **Non-control instruction with ex_pred_taken=1** (a stale alias): taken=0, so it mispredicts and redirects to ex_pc+4. Tables are not written.

## Timing
- **Reset (async, immediate)**:
  - pc = RESET_PC.
  - All btb_valid = 0; all BHT counters = 01 (weakly not-taken).
  - Consequently pred_taken = 0 and pred_target = RESET_PC+4.
- **After rst deasserts**: first PC advance at the first rising edge.
- **flush**: combinational, in the same cycle the instruction sits in execute. pc takes the corrected value at the next edge (1-cycle redirect latency).
- **Penalty**: correct predictions cost 0 bubbles; mispredictions cost exactly the two squashed younger slots.
- **Table writes**: become visible to fetch reads from the cycle after the update edge.
- **rst mid-flush**: reset wins; no table write occurs on that edge.

## Test plan
- **Reset**: rst pulse with RESET_PC=0x100 → pc=0x100, pred_taken=0, pred_target=0x104, flush=0. With no ex_valid and no stall, pc goes 0x104, 0x108 on successive edges.
- **Cold branch**: beq at ex_pc=0x20 with zero=1, target 0x80, ex_pred_taken=0 → flush=1 that cycle; next pc=0x80. BHT[8]=10, BTB[8] valid. A later fetch of 0x20 → pred_taken=1, pred_target=0x80.
- **All conditions**: for each f3 ∈ {000,001,100,101,110,111} with flag patterns zero/lt/ltu toggled, verify taken matches the condition list. f3=010 with all flags 1 → not taken.
- **Saturation and hysteresis**:
  - Four consecutive taken resolutions at one index → counter 11.
  - Then one not-taken → 10, still predicting taken.
  - A second not-taken → 01, fetch prediction becomes not-taken.
- **JALR target change**: JALR at 0x40 resolved to 0x200, then again with ex_target=0x300 and ex_pred_target=0x200 → flush=1, pc=0x300, BTB target updated.
- **Stall vs redirect**: with stall=1 and no mispredict, pc holds for 3 cycles. With stall=1 and a mispredict in the same cycle, pc still takes the redirect target at the next edge.
